pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core. It drives the write enables of PC, IF/ID and ID/EX, and the bubble/flush controls around the decode stage.
- Detects load-use hazards between the instruction in IF/ID and a load in ID/EX.
- Sequences branch/jump redirect flushes and freezes the whole front end while data memory is busy.
- Sits beside the decode stage. Consumes IF/ID instruction bits and ID/EX destination info. Feeds enables to stage1/stage2 pipeline registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 47 ++++
 rtl/pipe_hazard_ctrl_src_use_decode.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the decode-stage
// control logic: opcode constants, controller state encoding and small helpers.
package pipe_hazard_ctrl_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    localparam int FCNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                      ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                      ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam ctrl_t CTRL_FLUSH  = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                      ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_LU     = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1,
                                      ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam ctrl_t CTRL_RESET  = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                      ifid_flush: 1'b1, idex_bubble: 1'b1};

    function automatic logic [4:0] rs1_field(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] rs2_field(input logic [31:0] inst);
        return inst[24:20];
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_src_use_decode.sv
// Which source register fields an opcode actually reads; purely combinational
// so the future decode-stage control unit can share it.
module src_use_decode
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_rs1_used,
    output logic       o_rs2_used
);

    logic w_no_rs1;
    logic w_has_rs2;

    always_comb begin
        w_no_rs1  = 1'b0;
        w_has_rs2 = 1'b0;
        case (i_opcode)
            OP_LUI, OP_AUIPC, OP_JAL: w_no_rs1  = 1'b1;
            default:                  w_no_rs1  = 1'b0;
        endcase
        case (i_opcode)
            OP_R, OP_S, OP_B:         w_has_rs2 = 1'b1;
            default:                  w_has_rs2 = 1'b0;
        endcase
    end

    assign o_rs1_used = ~w_no_rs1;
    assign o_rs2_used = w_has_rs2;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side sequencing controller: load-use bubbles, redirect flushes and
// whole-front-end freeze on data memory stalls, plus saturating perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ifid_inst,
    input  logic             ifid_valid,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             idex_valid,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [FCNT_W-1:0] FC_LOAD   = FLUSH_CYCLES[FCNT_W-1:0];
    localparam logic              HAS_FLUSH = (FLUSH_CYCLES > 0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_rs1_hit;
    logic              w_rs2_hit;
    logic              w_lu;

    state_t            r_state;
    state_t            w_state_next;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_stall_inc;
    logic              w_flush_inc;
    ctrl_t             w_ctrl;
    ctrl_t             w_ctrl_out;

    src_use_decode u_src_use_decode (
        .i_opcode   (ifid_inst[6:0]),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used)
    );

    assign w_rs1_hit = w_rs1_used && (rs1_field(ifid_inst) == idex_rd);
    assign w_rs2_hit = w_rs2_used && (rs2_field(ifid_inst) == idex_rd);
    assign w_lu      = ifid_valid && idex_valid && idex_mem_read &&
                       (idex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    // Busy counts as lost time in every state; a squashed load-use still
    // registers as a hazard cycle even though no bubble is inserted for it.
    assign w_stall_inc = w_lu || dmem_busy;

    always_comb begin
        w_ctrl       = CTRL_RUN;
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        w_flush_inc  = 1'b0;
        case (r_state)
            ST_FLUSH: begin
                if (dmem_busy) begin
                    w_ctrl = CTRL_FREEZE;
                end else if (branch_taken) begin
                    w_ctrl      = CTRL_FLUSH;
                    w_flush_inc = 1'b1;
                    w_fcnt_next = FC_LOAD;
                end else begin
                    w_ctrl      = CTRL_FLUSH;
                    w_fcnt_next = r_fcnt - 1'b1;
                    if (r_fcnt <= 1) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            default: begin
                // MEM_WAIT decides exactly like RUN; it only records the freeze.
                if (dmem_busy) begin
                    w_ctrl       = CTRL_FREEZE;
                    w_state_next = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    w_ctrl      = CTRL_FLUSH;
                    w_flush_inc = 1'b1;
                    if (HAS_FLUSH) begin
                        w_state_next = ST_FLUSH;
                        w_fcnt_next  = FC_LOAD;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else if (w_lu) begin
                    w_ctrl       = CTRL_LU;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_fcnt      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
            if (w_stall_inc && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_inc && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    // Reset overrides the Mealy outputs immediately, not at the next edge.
    assign w_ctrl_out  = rst_n ? w_ctrl : CTRL_RESET;
    assign pc_we       = w_ctrl_out.pc_we;
    assign ifid_we     = w_ctrl_out.ifid_we;
    assign idex_we     = w_ctrl_out.idex_we;
    assign ifid_flush  = w_ctrl_out.ifid_flush;
    assign idex_bubble = w_ctrl_out.idex_bubble;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized checks of pipe_hazard_ctrl against a cycle-level
// behavioural model that tracks only "flush cycles remaining" and two counts.
module tb_pipe_hazard_ctrl;

    localparam int FC   = 2;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   ifid_inst;
    logic          ifid_valid;
    logic [4:0]    idex_rd;
    logic          idex_mem_read;
    logic          idex_valid;
    logic          branch_taken;
    logic          dmem_busy;
    logic          pc_we;
    logic          ifid_we;
    logic          ifid_flush;
    logic          idex_we;
    logic          idex_bubble;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;
    int m_flush_left = 0;
    int m_stall = 0;
    int m_flush = 0;
    int step_no = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifid_inst     (ifid_inst),
        .ifid_valid    (ifid_valid),
        .idex_rd       (idex_rd),
        .idex_mem_read (idex_mem_read),
        .idex_valid    (idex_valid),
        .branch_taken  (branch_taken),
        .dmem_busy     (dmem_busy),
        .pc_we         (pc_we),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_we       (idex_we),
        .idex_bubble   (idex_bubble),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    function automatic bit model_lu();
        logic [6:0] op;
        bit r1, r2;
        op = ifid_inst[6:0];
        r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        if (!(ifid_valid && idex_valid && idex_mem_read) || idex_rd == 0) return 1'b0;
        return (r1 && ifid_inst[19:15] == idex_rd) || (r2 && ifid_inst[24:20] == idex_rd);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    task automatic check_outputs(input bit e_pc, input bit e_ifid, input bit e_idex,
                                 input bit e_fl, input bit e_bb);
        check("pc_we", pc_we, e_pc);
        check("ifid_we", ifid_we, e_ifid);
        check("idex_we", idex_we, e_idex);
        check("ifid_flush", ifid_flush, e_fl);
        check("idex_bubble", idex_bubble, e_bb);
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic step(input string name);
        bit lu;
        @(negedge clk);
        step_no++;
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        lu = model_lu();
        if (!rst_n) begin
            check_outputs(0, 0, 0, 1, 1);
            m_flush_left = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (dmem_busy) begin
                check_outputs(0, 0, 0, 0, 0);
            end else if (branch_taken) begin
                check_outputs(1, 1, 1, 1, 1);
                m_flush_left = FC;
                if (m_flush < CMAX) m_flush++;
            end else if (m_flush_left > 0) begin
                check_outputs(1, 1, 1, 1, 1);
                m_flush_left--;
            end else if (lu) begin
                check_outputs(0, 0, 1, 0, 1);
            end else begin
                check_outputs(1, 1, 1, 0, 0);
            end
            if ((lu || dmem_busy) && m_stall < CMAX) m_stall++;
        end
        $display("step %0d %s: rst_n=%0b br=%0b busy=%0b lu=%0b -> pc=%0b ifid=%0b idex=%0b fl=%0b bb=%0b st=%0d fc=%0d",
                 step_no, name, rst_n, branch_taken, dmem_busy, lu, pc_we, ifid_we,
                 idex_we, ifid_flush, idex_bubble, stall_cnt, flush_cnt);
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0100011,
                7'b1100011, 7'b0010011, 7'b0000011, 7'b1100111};
        rst_n = 1'b0;
        ifid_inst = 32'h0000_0013;
        ifid_valid = 1'b0;
        idex_rd = 5'd0;
        idex_mem_read = 1'b0;
        idex_valid = 1'b0;
        branch_taken = 1'b0;
        dmem_busy = 1'b0;
        step("reset");
        step("reset");
        rst_n = 1'b1;
        step("idle");

        // Load x5 followed by add x6,x5,x1: one bubble cycle.
        ifid_valid = 1'b1; idex_valid = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd5;
        ifid_inst = enc(7'b0110011, 5'd6, 5'd5, 5'd1);
        step("load-use");
        idex_mem_read = 1'b0;
        step("load advanced");
        check("stall after lu", stall_cnt, 32'd1);

        // LUI never reads rs1, even if its field matches.
        idex_mem_read = 1'b1;
        ifid_inst = enc(7'b0110111, 5'd5, 5'd5, 5'd0);
        step("lui no stall");
        idex_rd = 5'd0;
        ifid_inst = enc(7'b0110011, 5'd6, 5'd0, 5'd0);
        step("rd x0 no stall");
        ifid_valid = 1'b0; idex_rd = 5'd5;
        ifid_inst = enc(7'b0110011, 5'd6, 5'd5, 5'd5);
        step("invalid ifid no stall");
        ifid_valid = 1'b1; idex_mem_read = 1'b0;

        // Single-cycle redirect: three flush cycles in total.
        branch_taken = 1'b1;
        step("branch");
        branch_taken = 1'b0;
        step("flush 1");
        step("flush 2");
        step("after flush");
        check("flush_cnt after branch", flush_cnt, 32'd1);

        // Busy for four cycles with a load-use pending, then the bubble.
        idex_mem_read = 1'b1; idex_rd = 5'd5;
        ifid_inst = enc(7'b0100011, 5'd0, 5'd2, 5'd5);
        dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) step("busy+lu");
        dmem_busy = 1'b0;
        step("lu after busy");
        idex_mem_read = 1'b0;
        step("resume");

        // Branch held through a two-cycle freeze.
        branch_taken = 1'b1; dmem_busy = 1'b1;
        step("busy+branch");
        step("busy+branch");
        dmem_busy = 1'b0;
        step("branch after busy");
        branch_taken = 1'b0;
        step("flush 1");
        dmem_busy = 1'b1;
        step("busy in flush");
        dmem_busy = 1'b0;
        step("flush 2");
        step("run");

        // Asynchronous reset in the middle of a flush.
        branch_taken = 1'b1;
        step("branch");
        branch_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async rst pc_we", pc_we, 32'd0);
        check("async rst ifid_flush", ifid_flush, 32'd1);
        check("async rst idex_bubble", idex_bubble, 32'd1);
        check("async rst stall_cnt", stall_cnt, 32'd0);
        check("async rst flush_cnt", flush_cnt, 32'd0);
        m_flush_left = 0; m_stall = 0; m_flush = 0;
        step("in reset");
        rst_n = 1'b1;
        step("after reset");
        step("after reset");

        // Randomized traffic with narrow register ranges so hazards are common.
        for (int i = 0; i < 1500; i++) begin
            ifid_inst = enc(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 31)),
                            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            ifid_valid = ($urandom_range(0, 9) != 0);
            idex_valid = ($urandom_range(0, 9) != 0);
            idex_mem_read = ($urandom_range(0, 1) != 0);
            idex_rd = 5'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 9) == 0);
            dmem_busy = ($urandom_range(0, 4) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
